// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, signs applied in a single fix-up cycle; fixed 33-cycle latency.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic [1:0]       dbg_state
);

  // Handshake: Start is taken on any edge where Busy=0 (it has priority over
  // HiWrite/LoWrite); while Busy=1 Start, HiWrite and LoWrite are all ignored.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] oper_q, oper_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign abs_a = (Op[0] && ReadData1[WIDTH-1]) ? -ReadData1 : ReadData1;
  assign abs_b = (Op[0] && ReadData2[WIDTH-1]) ? -ReadData2 : ReadData2;

  // Multiply keeps {partial, multiplier} in work_hi/work_lo and shifts right;
  // divide keeps {remainder, dividend->quotient} and shifts left.
  assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, oper_q} : '0);
  assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, oper_q};
  assign div_rem   = div_shift[WIDTH-1:0] - oper_q;

  assign product  = {work_hi_q, work_lo_q};
  assign prod_fix = neg_lo_q ? -product : product;
  assign quo_fix  = neg_lo_q ? -work_lo_q : work_lo_q;
  assign rem_fix  = neg_hi_q ? -work_hi_q : work_hi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rs_d      = rs_q;
    oper_d    = oper_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          op_d      = Op;
          rs_d      = ReadData1;
          work_hi_d = '0;
          neg_lo_d  = Op[0] & (ReadData1[WIDTH-1] ^ ReadData2[WIDTH-1]);
          neg_hi_d  = Op[0] & (Op[1] ? ReadData1[WIDTH-1]
                                     : (ReadData1[WIDTH-1] ^ ReadData2[WIDTH-1]));
          div0_d    = Op[1] && (ReadData2 == '0);
          if (Op[1]) begin
            work_lo_d = abs_a;
            oper_d    = abs_b;
          end else begin
            work_lo_d = abs_b;
            oper_d    = abs_a;
          end
        end else begin
          if (HiWrite) hi_d = WriteData;
          if (LoWrite) lo_d = WriteData;
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          work_hi_d = div_ge ? div_rem : div_shift[WIDTH-1:0];
          work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
        end else begin
          work_hi_d = mul_sum[WIDTH:1];
          work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div0_q) begin
          hi_d = rs_q;
          lo_d = '1;
        end else if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rs_q      <= '0;
      oper_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      oper_q    <= oper_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign HiOut     = hi_q;
  assign LoOut     = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops, checked against
// a plain-arithmetic HI/LO model through an expected-result queue.
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        Reset, Start, HiWrite, LoWrite;
  logic [1:0]  Op;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        Busy, Done;
  logic [31:0] HiOut, LoOut;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .HiOut(HiOut), .LoOut(LoOut),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      2'd0: return {32'b0, a} * {32'b0, b};
      2'd1: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic hw = 1'b0, input logic lw = 1'b0);
    exp_q.push_back(model(op, a, b));
    Op = op; ReadData1 = a; ReadData2 = b;
    Start = 1'b1; HiWrite = hw; LoWrite = lw; WriteData = $urandom;
    @(negedge Clock);
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    ReadData1 = $urandom; ReadData2 = $urandom; Op = 2'($urandom_range(0, 3));
    check("busy_rise", Busy, 1);
    check("done_low", Done, 0);
  endtask

  task automatic finish_op(input bit mid_pulse, input bit trail);
    int          busy_cnt;
    int          guard;
    logic [63:0] exp;
    busy_cnt = 0;
    guard = 0;
    while (!Done && guard < 60) begin
      if (Busy) busy_cnt++;
      if (busy_cnt == 16) begin
        check("hold_hi", HiOut, m_hi);
        check("hold_lo", LoOut, m_lo);
      end
      if (mid_pulse && busy_cnt == 10) begin
        Start = 1'b1; Op = 2'd2; HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
      end else begin
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      end
      @(negedge Clock);
      guard++;
    end
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    check("done_seen", Done, 1);
    check("busy_cycles", busy_cnt, 33);
    check("busy_at_done", Busy, 0);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'h0;
    check("hi", HiOut, exp[63:32]);
    check("lo", LoOut, exp[31:0]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    if (trail) begin
      @(negedge Clock);
      check("done_drop", Done, 0);
      check("stay_idle", Busy, 0);
    end
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
    HiWrite = hw; LoWrite = lw; WriteData = d;
    @(negedge Clock);
    HiWrite = 1'b0; LoWrite = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
    check("mt_hi", HiOut, m_hi);
    check("mt_lo", LoOut, m_lo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit seen_done;
    Reset = 1'b1; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    Op = '0; ReadData1 = '0; ReadData2 = '0; WriteData = '0;
    repeat (2) @(negedge Clock);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_hi", HiOut, 0);
    check("rst_lo", LoOut, 0);
    Reset = 1'b0;
    @(negedge Clock);

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op(0, 1);
    issue(2'd1, 32'hFFFF_FFFD, 32'd7);         finish_op(0, 1);
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);         finish_op(0, 1);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF); finish_op(0, 1);
    issue(2'd2, 32'd100, 32'd0);               finish_op(0, 1);
    issue(2'd2, 32'd100, 32'd7);               finish_op(0, 1);
    issue(2'd3, 32'hFFFF_FF9C, 32'd0);         finish_op(0, 1);

    // Busy-time Start/HiWrite/LoWrite are ignored
    issue(2'd0, 32'd5, 32'd5);                 finish_op(1, 1);
    mt(1'b0, 1'b1, 32'h0000_1234);
    mt(1'b1, 1'b1, 32'hCAFE_0001);
    // Start beats simultaneous MTHI/MTLO
    issue(2'd1, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1); finish_op(0, 1);
    // Back-to-back: new Start on the edge where Done drops
    issue(2'd2, 32'd1000, 32'd33);             finish_op(0, 0);
    issue(2'd1, 32'h8000_0000, 32'h8000_0000); finish_op(0, 1);

    // Reset in the middle of a DIV
    issue(2'd3, 32'hF000_0000, 32'd3);
    repeat (14) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_hi", HiOut, 0);
    check("abort_lo", LoOut, 0);
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge Clock);
      if (Done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    issue(2'd1, 32'hFFFF_FFF0, 32'd3);         finish_op(0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = pick();
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : pick();
      if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      issue(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
